// File: rtl/fir4_pkg.sv
// Shared widths and types for the 4-tap scan-loaded FIR.
package fir4_pkg;

  localparam int DATA_W  = 8;
  localparam int TAPS    = 4;
  localparam int DIV     = 4;
  localparam int OUT_W   = 2*DATA_W + $clog2(TAPS);
  localparam int CHAIN_W = TAPS*DATA_W;

  typedef logic [DATA_W-1:0]   sample_t;
  typedef logic [DATA_W-1:0]   coef_t;
  typedef logic [2*DATA_W-1:0] prod_t;
  typedef logic [OUT_W-1:0]    result_t;

  function automatic prod_t mul(input sample_t s, input coef_t c);
    return prod_t'(s) * prod_t'(c);
  endfunction

endpackage

// File: rtl/fir4_scan_coef_if.sv
// Sample/result bus plus coefficient scan port of the FIR.
interface fir4_scan_coef_if;
  import fir4_pkg::*;

  logic    shift_en;
  logic    shift_in;
  sample_t a;
  result_t y;
  logic    sample_stb;

  modport master (output shift_en, shift_in, a, input y, sample_stb);
  modport slave  (input shift_en, shift_in, a, output y, sample_stb);

endinterface

// File: rtl/coef_scan_chain.sv
// Serial-in coefficient register {c0,c1,c2,c3}; c0 sits at the MSB end so an
// MSB-first load finishes with the first shifted bit in c0[7].
module coef_scan_chain
  import fir4_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  shift_en,
  input  logic  shift_in,
  output coef_t c0,
  output coef_t c1,
  output coef_t c2,
  output coef_t c3
);

  logic [CHAIN_W-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else if (shift_en) begin
      chain <= {chain[CHAIN_W-2:0], shift_in};
    end
  end

  assign c0 = chain[CHAIN_W-1          -: DATA_W];
  assign c1 = chain[CHAIN_W-1-DATA_W   -: DATA_W];
  assign c2 = chain[2*DATA_W-1         -: DATA_W];
  assign c3 = chain[DATA_W-1:0];

endmodule

// File: rtl/fir4_scan_coef.sv
// 4-tap unsigned FIR sampling once every DIV clocks; coefficients come from
// the scan chain and are used as they stand before the sample edge.
module fir4_scan_coef
  import fir4_pkg::*;
(
  input logic            clk,
  input logic            reset,
  fir4_scan_coef_if.slave bus
);

  logic [1:0] phase;
  logic       sample_cyc;
  sample_t    x0, x1, x2;
  coef_t      c0, c1, c2, c3;
  result_t    acc;
  result_t    y_q;
  logic       stb_q;

  coef_scan_chain u_chain (
    .clk      (clk),
    .reset    (reset),
    .shift_en (bus.shift_en),
    .shift_in (bus.shift_in),
    .c0       (c0),
    .c1       (c1),
    .c2       (c2),
    .c3       (c3)
  );

  assign sample_cyc = (phase == 2'(DIV-1));

  // Products are at most 16 bits; the 18-bit sum cannot overflow.
  always_comb begin
    acc = result_t'(mul(bus.a, c0)) + result_t'(mul(x0, c1))
        + result_t'(mul(x1, c2))    + result_t'(mul(x2, c3));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
      x0    <= '0;
      x1    <= '0;
      x2    <= '0;
      y_q   <= '0;
      stb_q <= 1'b0;
    end else begin
      phase <= phase + 2'd1;
      stb_q <= sample_cyc;
      if (sample_cyc) begin
        y_q <= acc;
        x0  <= bus.a;
        x1  <= x0;
        x2  <= x1;
      end
    end
  end

  assign bus.y          = y_q;
  assign bus.sample_stb = stb_q;

endmodule

// File: tb/tb_fir4_scan_coef.sv
// Randomized bench for fir4_scan_coef against a sample-history reference model.
module tb_fir4_scan_coef;
  import fir4_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fir4_scan_coef_if bus();

  fir4_scan_coef dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int          n_checks;
  int          n_pass;
  logic [31:0] scan_word;
  int          samples[$];
  int          strobes[$];
  int          cyc;
  longint      exp_y;
  bit          exp_stb;

  task automatic check(input string tag, input longint obs, input longint expv);
    n_checks++;
    if (obs == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
  endtask

  task automatic model_reset();
    scan_word = '0;
    samples.delete();
    cyc     = 0;
    exp_y   = 0;
    exp_stb = 0;
  endtask

  function automatic longint coef(input int k);
    return longint'((scan_word >> (8*(3-k))) & 32'hff);
  endfunction

  function automatic longint ref_y();
    longint s = 0;
    int n = samples.size();
    for (int k = 0; k < 4; k++)
      if (n-1-k >= 0) s += coef(k) * longint'(samples[n-1-k]);
    return s;
  endfunction

  // Called at a negedge: drive, let one rising edge pass, check, return at next negedge.
  task automatic tick(input bit se, input bit si, input int av);
    bus.shift_en = se;
    bus.shift_in = si;
    bus.a        = av[7:0];
    @(posedge clk);
    if (cyc % DIV == DIV-1) begin
      samples.push_back(av & 255);
      exp_y   = ref_y();
      exp_stb = 1;
    end else begin
      exp_stb = 0;
    end
    if (se) scan_word = {scan_word[30:0], si};
    cyc++;
    #1;
    check("y", bus.y, exp_y);
    check("sample_stb", bus.sample_stb, exp_stb);
    if (bus.sample_stb) strobes.push_back(int'(bus.y));
    @(negedge clk);
  endtask

  task automatic load(input int k0, input int k1, input int k2, input int k3, input bit rand_a);
    logic [31:0] w;
    w = {k0[7:0], k1[7:0], k2[7:0], k3[7:0]};
    for (int i = 31; i >= 0; i--)
      tick(1'b1, w[i], rand_a ? int'($urandom_range(0, 255)) : 0);
  endtask

  function automatic int strobe_at(input int i);
    return (i < strobes.size()) ? strobes[i] : -1;
  endfunction

  int imp_exp[5];
  int max_exp[4];
  int rc[4];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    imp_exp  = '{10, 20, 30, 40, 0};
    max_exp  = '{65025, 130050, 195075, 260100};
    reset = 1'b1;
    bus.shift_en = 1'b0;
    bus.shift_in = 1'b0;
    bus.a        = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_y", bus.y, 0);
    check("rst_stb", bus.sample_stb, 0);
    reset = 1'b0;

    repeat (12) tick(1'b0, 1'b0, 0);

    load(1, 2, 3, 4, 1'b0);
    check("c0_load", dut.c0, 1);
    check("c1_load", dut.c1, 2);
    check("c2_load", dut.c2, 3);
    check("c3_load", dut.c3, 4);
    repeat (6) tick(1'b0, 1'($urandom_range(0, 1)), 0);
    check("c0_hold", dut.c0, 1);
    check("c1_hold", dut.c1, 2);
    check("c2_hold", dut.c2, 3);
    check("c3_hold", dut.c3, 4);

    strobes.delete();
    repeat (4) tick(1'b0, 1'b0, 10);
    repeat (20) tick(1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) check("impulse", strobe_at(i), imp_exp[i]);

    load(255, 255, 255, 255, 1'b0);
    strobes.delete();
    repeat (16) tick(1'b0, 1'b0, 255);
    repeat (4) tick(1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++) check("max", strobe_at(i), max_exp[i]);

    for (int i = 0; i < 4; i++) rc[i] = int'($urandom_range(1, 255));
    load(rc[0], rc[1], rc[2], rc[3], 1'b1);
    repeat (4000) tick(1'b0, 1'b0, int'($urandom_range(0, 255)));

    repeat (96) tick(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));

    #2 reset = 1'b1;
    #1;
    check("mid_y", bus.y, 0);
    check("mid_stb", bus.sample_stb, 0);
    check("mid_x0", dut.x0, 0);
    check("mid_x1", dut.x1, 0);
    check("mid_x2", dut.x2, 0);
    check("mid_c0", dut.c0, 0);
    check("mid_c1", dut.c1, 0);
    check("mid_c2", dut.c2, 0);
    check("mid_c3", dut.c3, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (40) tick(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fir4_scan_coef.md
Name: fir4_scan_coef

Overview:
- 4-tap unsigned FIR filter with coefficients loaded serially through a scan chain.
- Input samples are taken once every 4 clocks by an internal divide-by-4 sample strobe.
- Output is y = c0·x[n] + c1·x[n-1] + c2·x[n-2] + c3·x[n-3].
- Sits at chip top, between the pad-level sample bus and the result bus; the scan port is used for coefficient configuration.

Parameters:
- DATA_W, 8, width of input sample a and of each coefficient
- TAPS, 4, number of filter taps (fixed at 4; parameter is documentation only)
- DIV, 4, clock cycles per input sample
- OUT_W, 18, output width (2·DATA_W + log2(TAPS))

Ports:
- clk  input  1  single system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- shift_en  input  1  when high, the coefficient chain shifts one bit this clock
- shift_in  input  1  serial coefficient data
- a  input  DATA_W  input sample, captured on sample cycles only
- y  output  OUT_W  registered filter result
- sample_stb  output  1  one-cycle pulse marking the cycle in which y has just updated

Behaviour:
- Reset (async, active high) clears:
  - phase counter = 0
  - delay registers x0..x2 = 0
  - coefficients c0..c3 = 0
  - y = 0
  - sample_stb = 0
- Phase counter: 2 bits, counts 0,1,2,3,0… on every clk after reset deasserts. Cycle with count==DIV-1 is a sample cycle.
- Sample-cycle edge actions:
  - y <= c0·a + c1·x0 + c2·x1 + c3·x2
  - x0 <= a, x1 <= x0, x2 <= x1
  - On all other cycles, x* and y hold.
- sample_stb: registered; high for exactly the one cycle following each sample edge, i.e. 1 of every 4 cycles. The first pulse occurs in the 5th cycle after reset release.
- Arithmetic:
  - all unsigned; products are 16 bits; sum is zero-extended to OUT_W.
  - Max is 4·255·255 = 260100 < 2^18, so no overflow or saturation is needed.
- Coefficient scan chain:
  - 32-bit register {c0,c1,c2,c3}, with c0 at the MSB end.
  - Each clk with shift_en=1: chain <= {chain[30:0], shift_in}.
  - Load is MSB-first: bit 1 shifted becomes c0[7] after exactly 32 shifts; bit 32 becomes c3[0].
  - shift_en=0 holds the chain.
  - Shifting is independent of the phase counter. On a sample edge that coincides with a shift, the arithmetic uses the pre-edge coefficient values.
- Reset mid-operation: everything returns to reset values immediately; the phase restarts at 0 on release.
- Latency: a sample presented on sample cycle n appears in y (weighted by c0) in the next cycle. Its c3 contribution appears three samples (12 clocks) later.

Decomposition:
- Package fir4_pkg:
  - DATA_W, OUT_W, DIV constants
  - typedef sample_t (logic [DATA_W-1:0])
  - typedef coef_t (logic [DATA_W-1:0])
- One sub-module is natural: coef_scan_chain (32-bit serial-in shift register exposing c0..c3).
- Datapath and phase counter stay in the top-level module.

Test Plan:
1. Reset then idle: hold reset 2 cycles, release -> y=0; sample_stb pulses every 4 cycles starting at cycle 5.
2. Coefficient load: shift 32 bits encoding c0=1, c1=2, c2=3, c3=4 (MSB-first, c0 first) -> internal c0..c3 read 1,2,3,4; no change while shift_en=0.
3. Impulse: coefficients 1,2,3,4; a=10 on one sample cycle, 0 otherwise -> successive y after strobes = 10, 20, 30, 40, 0.
4. Max values: all coefficients 255, a=255 on 4 consecutive samples -> y = 65025, 130050, 195075, 260100; no wrap.
5. Random stream: 1000 random samples with random coefficients -> each y after sample_stb equals c0·a[n]+c1·a[n-1]+c2·a[n-2]+c3·a[n-3] from a reference model.
6. Shift during sampling and mid-run reset: shift new coefficients across a sample edge -> that edge uses the old coefficients. Assert reset mid-stream -> y, x*, c* and sample_stb go to 0 immediately, before the next clk edge.
